// File: rtl/serial_fsm_arbiter.sv
// ============================================================================
// Module   : serial_fsm_arbiter
// Brief    : Round-robin burst arbiter sharing one serial-input FSM between
//            NREQ requesters. Optional stats counters under ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fsm_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 4,
    parameter int ID_W      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    input  logic            y_in,
    output logic [NREQ-1:0] grant,
    output logic            a_out,
    output logic            a_vld,
    output logic            fsm_clr,
    output logic            y_out,
    output logic [ID_W-1:0] y_owner,
    output logic            y_vld,
    output logic            busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]     burst_cnt,
    output logic [15:0]     early_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [ID_W-1:0] owner_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [NREQ-1:0] grant_q;
    logic            a_out_q;
    logic            a_vld_q;
    logic            fsm_clr_q;
    logic            y_out_q;
    logic [ID_W-1:0] y_owner_q;
    logic            y_vld_q;
    logic            busy_q;

    logic            found_d;
    logic [ID_W-1:0] win_d;
    logic [ID_W-1:0] idx_d;
    logic [NREQ-1:0] onehot_d;
    logic [ID_W-1:0] rr_next_d;
    logic            last_bit_d;
    logic            y_take_d;

    // First requester at or above rr_ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        idx_d   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_d = ID_W'((int'(rr_ptr_q) + i) % NREQ);
            if (!found_d && req[idx_d]) begin
                found_d = 1'b1;
                win_d   = idx_d;
            end
        end
    end

    assign onehot_d   = NREQ'(1) << win_d;
    assign rr_next_d  = (owner_q == ID_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign last_bit_d = (bit_cnt_q == CNT_W'(BURST_LEN - 1));
    assign y_take_d   = (state_q == S_RUN) && a_vld_q;

`ifdef ARB_STATS_EN
    logic [15:0] burst_cnt_q;
    logic [15:0] early_cnt_q;
    assign burst_cnt = burst_cnt_q;
    assign early_cnt = early_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            bit_cnt_q <= '0;
            grant_q   <= '0;
            a_out_q   <= 1'b0;
            a_vld_q   <= 1'b0;
            fsm_clr_q <= 1'b0;
            y_out_q   <= 1'b0;
            y_owner_q <= '0;
            y_vld_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARB_STATS_EN
            burst_cnt_q <= '0;
            early_cnt_q <= '0;
`endif
        end else begin
            // Output tag trails each driven bit by one cycle.
            y_vld_q   <= y_take_d;
            y_out_q   <= y_take_d & y_in;
            y_owner_q <= y_take_d ? owner_q : '0;

            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        owner_q   <= win_d;
                        grant_q   <= onehot_d;
                        fsm_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= S_CLR;
                    end
                end
                S_CLR: begin
                    fsm_clr_q <= 1'b0;
                    bit_cnt_q <= '0;
                    a_vld_q   <= req[owner_q];
                    a_out_q   <= req[owner_q] & din[owner_q];
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    if (a_vld_q && !last_bit_d) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        a_vld_q   <= req[owner_q];
                        a_out_q   <= req[owner_q] & din[owner_q];
                    end else begin
                        // A RUN cycle without a bit means the owner released early.
                        grant_q  <= '0;
                        a_vld_q  <= 1'b0;
                        a_out_q  <= 1'b0;
                        rr_ptr_q <= rr_next_d;
                        state_q  <= S_GAP;
`ifdef ARB_STATS_EN
                        if (burst_cnt_q != 16'hFFFF) begin
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                        end
                        if (!a_vld_q && early_cnt_q != 16'hFFFF) begin
                            early_cnt_q <= early_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                S_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant   = grant_q;
    assign a_out   = a_out_q;
    assign a_vld   = a_vld_q;
    assign fsm_clr = fsm_clr_q;
    assign y_out   = y_out_q;
    assign y_owner = y_owner_q;
    assign y_vld   = y_vld_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire
